// File: rtl/nl_mux_pkg.sv
// Shared types and one-hot helpers for the registered one-hot mux.
package nl_mux_pkg;

  localparam int MAX_N = 64;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  function automatic logic is_onehot(input logic [MAX_N-1:0] v);
    return $countones(v) == 1;
  endfunction

  // Highest set index wins; zero input yields zero.
  function automatic logic [MAX_N-1:0] oh_pick_hi(input logic [MAX_N-1:0] v);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++)
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    return r;
  endfunction

endpackage

// File: rtl/nl_mux_oh_reg_select_if.sv
// Channel-side and link-side signals of the one-hot register mux.
interface nl_mux_oh_reg_select_if #(
  parameter type dtype_t = byte,
  parameter int  N       = 4,
  parameter int  CNT_W   = 8
);
  dtype_t           data_in [N-1:0];
  logic [N-1:0]     select;
  logic             in_valid;
  logic             in_ready;
  dtype_t           data_out;
  logic             out_valid;
  logic             out_ready;
  logic             sel_err;
  logic [CNT_W-1:0] err_count;
  logic             err_clr;

  modport master (
    output data_in, select, in_valid, out_ready, err_clr,
    input  in_ready, data_out, out_valid, sel_err, err_count
  );

  modport slave (
    input  data_in, select, in_valid, out_ready, err_clr,
    output in_ready, data_out, out_valid, sel_err, err_count
  );
endinterface

// File: rtl/nl_skid_buf.sv
// Valid/ready output register with an optional second (skid) entry.
module nl_skid_buf
  import nl_mux_pkg::*;
#(
  parameter type dtype_t = byte,
  parameter bit  SKID    = 1'b1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  dtype_t in_data,
  input  logic   in_valid,
  output logic   in_ready,
  output dtype_t out_data,
  output logic   out_valid,
  input  logic   out_ready
);
  state_t state;
  dtype_t skid_data;
  logic   acc, emit;

  // With SKID the ready only depends on held state; without it the single
  // register can refill in the same cycle it drains.
  assign in_ready = rst_n && (SKID ? (state != TWO) : (state == EMPTY || out_ready));
  assign acc      = in_valid && in_ready;
  assign emit     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
          state     <= ONE;
        end
        ONE: begin
          if (acc && emit) begin
            out_data <= in_data;
          end else if (acc) begin
            skid_data <= in_data;
            state     <= TWO;
          end else if (emit) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: if (emit) begin
          out_data <= skid_data;
          state    <= ONE;
        end
        default: begin
          out_valid <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end
endmodule

// File: rtl/nl_mux_oh_reg_select.sv
// Registered, flow-controlled N:1 mux with one-hot select and select-error tracking.
module nl_mux_oh_reg_select
  import nl_mux_pkg::*;
#(
  parameter type dtype_t = byte,
  parameter int  N       = 4,
  parameter bit  SKID    = 1'b1,
  parameter int  CNT_W   = 8
) (
  input logic clk,
  input logic rst_n,
  nl_mux_oh_reg_select_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]     pick;
  dtype_t           sel_data;
  logic             in_ready;
  logic             bad;
  logic             sel_err;
  logic [CNT_W-1:0] err_count;

  assign pick = N'(oh_pick_hi(MAX_N'(bus.select)));

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++)
      if (pick[i]) sel_data = bus.data_in[i];
  end

  nl_skid_buf #(.dtype_t(dtype_t), .SKID(SKID)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (sel_data),
    .in_valid (bus.in_valid),
    .in_ready (in_ready),
    .out_data (bus.data_out),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready)
  );

  assign bus.in_ready = in_ready;
  assign bad = bus.in_valid && in_ready && !is_onehot(MAX_N'(bus.select));

  // A new error in the clear cycle restarts the count at one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end else if (bad) begin
      sel_err   <= 1'b1;
      err_count <= bus.err_clr ? CNT_W'(1) :
                   (err_count == CNT_MAX) ? err_count : err_count + CNT_W'(1);
    end else if (bus.err_clr) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end
  end

  assign bus.sel_err   = sel_err;
  assign bus.err_count = err_count;
endmodule

// File: tb/tb_nl_mux_oh_reg_select.sv
// Drives a SKID=0 and a SKID=1 instance in lockstep against a queue-style reference model.
module tb_nl_mux_oh_reg_select;
  logic       clk = 1'b0;
  logic       rst_n;
  byte        din [3:0];
  logic [3:0] sel;
  logic       in_valid, out_ready, err_clr;

  int nvec = 0;
  int nerr = 0;

  // Model: per instance, an ordered list of held items (front = data_out).
  logic [7:0] m_item [2][2];
  int         m_cnt  [2];
  logic [7:0] m_last [2];
  logic       m_err  [2];
  int         m_ecnt [2];

  nl_mux_oh_reg_select_if #(.dtype_t(byte), .N(4), .CNT_W(2)) bus0 ();
  nl_mux_oh_reg_select_if #(.dtype_t(byte), .N(4), .CNT_W(2)) bus1 ();

  assign bus0.data_in = din;   assign bus1.data_in = din;
  assign bus0.select = sel;    assign bus1.select = sel;
  assign bus0.in_valid = in_valid;   assign bus1.in_valid = in_valid;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;
  assign bus0.err_clr = err_clr;     assign bus1.err_clr = err_clr;

  nl_mux_oh_reg_select #(.dtype_t(byte), .N(4), .SKID(1'b0), .CNT_W(2)) u_reg (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  nl_mux_oh_reg_select #(.dtype_t(byte), .N(4), .SKID(1'b1), .CNT_W(2)) u_skid (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [7:0] pv;
    bit acc [2];
    bit emit [2];
    bit rdy, bad_sel;
    #1;
    pv = 8'h00;
    for (int i = 3; i >= 0; i--)
      if (sel[i]) begin pv = din[i]; break; end
    bad_sel = $countones(sel) != 1;
    for (int d = 0; d < 2; d++) begin
      rdy = rst_n && ((d == 1) ? (m_cnt[d] < 2) : (m_cnt[d] == 0 || out_ready));
      chk($sformatf("skid%0d.in_ready", d), {31'b0, (d == 1) ? bus1.in_ready : bus0.in_ready}, {31'b0, rdy});
      acc[d]  = in_valid && rdy;
      emit[d] = m_cnt[d] > 0 && out_ready;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_cnt[d] = 0; m_last[d] = 8'h00; m_err[d] = 1'b0; m_ecnt[d] = 0;
      end else begin
        if (emit[d]) begin m_item[d][0] = m_item[d][1]; m_cnt[d]--; end
        if (acc[d])  begin m_item[d][m_cnt[d]] = pv; m_cnt[d]++; end
        if (acc[d] && bad_sel) begin
          m_err[d]  = 1'b1;
          m_ecnt[d] = err_clr ? 1 : ((m_ecnt[d] < 3) ? m_ecnt[d] + 1 : 3);
        end else if (err_clr) begin
          m_err[d] = 1'b0; m_ecnt[d] = 0;
        end
        if (m_cnt[d] > 0) m_last[d] = m_item[d][0];
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("skid%0d.out_valid", d), {31'b0, (d == 1) ? bus1.out_valid : bus0.out_valid}, {31'b0, m_cnt[d] > 0});
      chk($sformatf("skid%0d.data_out", d), {24'b0, (d == 1) ? bus1.data_out : bus0.data_out}, {24'b0, m_last[d]});
      chk($sformatf("skid%0d.sel_err", d), {31'b0, (d == 1) ? bus1.sel_err : bus0.sel_err}, {31'b0, m_err[d]});
      chk($sformatf("skid%0d.err_count", d), {30'b0, (d == 1) ? bus1.err_count : bus0.err_count}, 32'(m_ecnt[d]));
    end
  endtask

  task automatic set_data(input byte d3, input byte d2, input byte d1, input byte d0);
    din[3] = d3; din[2] = d2; din[1] = d1; din[0] = d0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_last[d] = 8'h00; m_err[d] = 1'b0; m_ecnt[d] = 0;
    end
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; sel = 4'b0000;
    set_data(0, 0, 0, 0);
    repeat (2) step();

    // Basic flow: select channel 1 continuously.
    rst_n = 1'b1;
    set_data(4, 3, 2, 1); sel = 4'b0010; in_valid = 1'b1; out_ready = 1'b1;
    repeat (4) step();

    // Drain, then backpressure while offering A, B, C.
    in_valid = 1'b0; step();
    out_ready = 1'b0; in_valid = 1'b1; sel = 4'b0001;
    din[0] = 8'hA0; step();
    din[0] = 8'hB0; step();
    din[0] = 8'hC0; step();
    out_ready = 1'b1; step();
    in_valid = 1'b0; repeat (4) step();

    // Toggling downstream ready with continuous offers.
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      out_ready = ~k[0];
      din[2] = byte'(8'h10 + k); sel = 4'b0100;
      step();
    end
    out_ready = 1'b1; in_valid = 1'b0; repeat (3) step();

    // Non-one-hot selects.
    set_data(4, 3, 2, 1); in_valid = 1'b1;
    sel = 4'b0110; step();
    sel = 4'b0000; step();
    in_valid = 1'b0; step();

    // Saturation, then clear colliding with a new error, then clear alone.
    in_valid = 1'b1; sel = 4'b1100;
    repeat (5) step();
    err_clr = 1'b1; step();
    in_valid = 1'b0; step();
    err_clr = 1'b0; step();

    // Fill the buffer, reset, and make sure nothing buffered reappears.
    out_ready = 1'b0; in_valid = 1'b1; sel = 4'b0011;
    set_data(8'h55, 8'h66, 8'h77, 8'h88);
    repeat (3) step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; repeat (3) step();

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 4; i++) din[i] = byte'($urandom);
      sel       = ($urandom_range(0, 9) < 7) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      err_clr   = $urandom_range(0, 19) == 0;
      rst_n     = $urandom_range(0, 99) != 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
